crc_frame_engine: RTL and testbench
===================================

Name: crc_frame_engine

Overview:
- Parametrised successor to the team's byte-serial CRC-32 block.
- Accepts framed data DATA_BYTES per beat with a valid/ready handshake, and supports partial final beats.
- Computes any CRC from 8 to 32 bits: configurable polynomial, init, reflection and output XOR.
- Holds the result until consumed and flags FCS residue match, so Ethernet/UDP RX can verify frames and TX can generate them.

Parameters:
CRC_W, 32, CRC width in bits (8..32)
DATA_BYTES, 4, bytes per input beat (1..8); byte 0 = in_data[7:0] is first on the wire
POLY, 32'h04C11DB7, normal-form polynomial (low CRC_W bits used)
INIT, 32'hFFFFFFFF, register preset at frame start
XOR_OUT, 32'hFFFFFFFF, XOR applied to the register to form crc_value
REFLECT, 1, 1 = LSB-first (reflected input and output); 0 = MSB-first
RESIDUE, 32'hDEBB20E3, expected register value (before XOR_OUT) after data+FCS

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  beat offered
in_ready  out  1  beat accepted when in_valid & in_ready
in_data  in  8*DATA_BYTES  beat data
in_sof  in  1  first beat of frame
in_eof  in  1  last beat of frame
in_keep  in  DATA_BYTES  valid-byte mask on eof beat; contiguous from bit 0; ignored on non-eof beats
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid & out_ready
crc_value  out  CRC_W  final CRC (register ^ XOR_OUT, numeric form)
crc_ok  out  1  register before XOR_OUT == RESIDUE
err_orphan  out  1  one-cycle pulse: beat accepted in IDLE without in_sof (beat dropped)
err_restart  out  1  one-cycle pulse: in_sof accepted while RUN (old frame abandoned)

Behaviour:
- Reset is asynchronous, active-high. It clears state to IDLE, register to INIT, and out_valid, crc_value, crc_ok, err_* to 0. in_ready is 1 after reset.
- Reset mid-frame or with a result pending discards everything. No output is produced.
- States:
  - IDLE: no frame open.
  - RUN: frame open, accumulating.
  - DONE: result held.
- IDLE transitions:
  - Accepted beat with sof & !eof: register = step(INIT, beat) → RUN.
  - sof & eof: result formed → DONE.
  - Beat without sof: dropped, err_orphan pulses, stay IDLE.
- RUN transitions:
  - Accepted non-eof beat: register = step(register, all bytes).
  - eof beat: fold in in_keep bytes → DONE.
  - sof beat: restart from INIT, err_restart pulses; sof&eof also → DONE.
- DONE:
  - out_valid = 1; crc_value and crc_ok stable.
  - On out_ready: → IDLE, out_valid = 0 next cycle.
- in_ready = (state != DONE) | out_ready. This gives zero-bubble back-to-back frames: an accepted sof beat in the same cycle that DONE is consumed starts the next frame.
- Latency: out_valid rises on the clock edge that accepts the eof beat, i.e. visible the cycle after acceptance. Throughput is one beat per cycle.
- step(): DATA_BYTES sequential byte updates, each 8 bit-serial shifts.
  - REFLECT=1: shift right using reflected POLY; data bits LSB first.
  - REFLECT=0: shift left; data bits MSB first. For CRC_W<8, not supported.
- Partial beat: only bytes with in_keep set (contiguous from byte 0) are folded.
  - in_keep==0 on eof: beat contributes nothing.
  - Non-contiguous keep: behaviour undefined; an assertion in the bench flags it.
- Output ordering: REFLECT=1 presents the register as-is (numeric value, LSB = first transmitted bit); no byte swap is applied. Byte swapping for wire order is the consumer's job.
- Empty frame is impossible except sof&eof&keep==0. In that case crc_value = INIT ^ XOR_OUT.

Decomposition:
- Package crc_pkg holds:
  - function reflect_n;
  - function crc_byte_step(crc, byte, poly, reflect);
  - state enum typedef {IDLE, RUN, DONE};
  - preset constants CRC32_ETH (POLY/INIT/XOR_OUT/RESIDUE), CRC16_CCITT, CRC8_SMBUS.
- One combinational sub-module, crc_beat_step: DATA_BYTES-stage unrolled update with keep masking. Register, FSM and handshake stay in crc_frame_engine.

Test Plan:
- Defaults, frame "123456789" as beats "1234","5678","9" (keep=4'b0001) → one cycle after eof: out_valid=1, crc_value=32'hCBF43926, crc_ok=0.
- Same 9 bytes followed by FCS bytes 26 39 F4 CB (eof beat keep=4'b1111 spanning "9",26,39,F4 then CB keep=0001) → crc_ok=1, crc_value=32'h2144DF1C.
- Two back-to-back frames with out_ready held 0 for 5 cycles after the first eof → in_ready=0 during hold. On out_ready=1 the first result pops and the second frame's sof is accepted the same cycle. Second CRC is correct.
- Beat without sof in IDLE → err_orphan pulse 1 cycle, no out_valid. Then sof mid-RUN → err_restart, and the CRC equals that of the new frame only.
- Assert rst for 1 cycle mid-frame (async, not clock aligned) → out_valid=0, state IDLE. The next "123456789" frame still gives 32'hCBF43926.
- CRC_W=16, POLY=16'h1021, INIT=16'hFFFF, XOR_OUT=0, REFLECT=0, DATA_BYTES=1, "123456789" → crc_value=16'h29B1. Also sof&eof&keep=0 → crc_value=16'hFFFF.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC helpers, FSM state type and standard algorithm presets for the
// frame-based CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] CRC32_ETH_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC32_ETH_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_ETH_XOR_OUT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_ETH_RESIDUE   = 32'hDEBB20E3;

  localparam logic [31:0] CRC16_CCITT_POLY    = 32'h00001021;
  localparam logic [31:0] CRC16_CCITT_INIT    = 32'h0000FFFF;
  localparam logic [31:0] CRC16_CCITT_XOR_OUT = 32'h00000000;
  localparam logic [31:0] CRC16_CCITT_RESIDUE = 32'h00000000;

  localparam logic [31:0] CRC8_SMBUS_POLY     = 32'h00000007;
  localparam logic [31:0] CRC8_SMBUS_INIT     = 32'h00000000;
  localparam logic [31:0] CRC8_SMBUS_XOR_OUT  = 32'h00000000;
  localparam logic [31:0] CRC8_SMBUS_RESIDUE  = 32'h00000000;

  function automatic logic [31:0] width_mask(input int width);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Bit-reverses the low `width` bits; upper bits of the result are zero.
  function automatic logic [31:0] reflect_n(input logic [31:0] value, input int width);
    logic [31:0] v;
    logic [31:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        r = {r[30:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] crc_byte_step(input logic [31:0] crc,
                                                input logic [7:0]  data,
                                                input logic [31:0] poly,
                                                input logic        reflect,
                                                input int          width);
    logic [31:0] mask;
    logic [31:0] c;
    logic [31:0] p;
    logic [31:0] top;
    logic        fb;
    mask = width_mask(width);
    c    = crc & mask;
    if (reflect) begin
      p = reflect_n(poly & mask, width);
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ data[i];
        c  = c >> 1;
        if (fb) c = c ^ p;
      end
    end else begin
      p   = poly & mask;
      top = 32'h1 << (width - 1);
      for (int i = 7; i >= 0; i--) begin
        fb = ((c & top) != 32'h0) ^ data[i];
        c  = (c << 1) & mask;
        if (fb) c = c ^ p;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_beat_step.sv
// Combinational CRC update across one beat: byte 0 is folded first, and
// bytes whose keep bit is clear pass the register through unchanged.
module crc_beat_step
  import crc_pkg::*;
#(
  parameter int          CRC_W      = 32,
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] POLY       = CRC32_ETH_POLY,
  parameter bit          REFLECT    = 1'b1
) (
  input  logic [CRC_W-1:0]        crc_in,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  output logic [CRC_W-1:0]        crc_out
);

  logic [CRC_W-1:0] stage [DATA_BYTES+1];

  assign stage[0] = crc_in;

  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_byte
    logic [CRC_W-1:0] stepped;
    assign stepped = CRC_W'(crc_byte_step(32'(stage[gi]), data[8*gi +: 8],
                                          POLY, REFLECT, CRC_W));
    assign stage[gi+1] = keep[gi] ? stepped : stage[gi];
  end

  assign crc_out = stage[DATA_BYTES];

endmodule

// File: rtl/crc_frame_engine.sv
// Framed, parametrised CRC engine: accumulates beats between sof and eof,
// then holds crc_value/crc_ok until the consumer takes the result.
module crc_frame_engine
  import crc_pkg::*;
#(
  parameter int          CRC_W      = 32,
  parameter int          DATA_BYTES = 4,
  parameter logic [31:0] POLY       = CRC32_ETH_POLY,
  parameter logic [31:0] INIT       = CRC32_ETH_INIT,
  parameter logic [31:0] XOR_OUT    = CRC32_ETH_XOR_OUT,
  parameter bit          REFLECT    = 1'b1,
  parameter logic [31:0] RESIDUE    = CRC32_ETH_RESIDUE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic                    in_sof,
  input  logic                    in_eof,
  input  logic [DATA_BYTES-1:0]   in_keep,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CRC_W-1:0]        crc_value,
  output logic                    crc_ok,
  output logic                    err_orphan,
  output logic                    err_restart
);

  localparam logic [CRC_W-1:0] INIT_W    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_W     = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RESIDUE_W = RESIDUE[CRC_W-1:0];

  state_t           state_reg, state_next;
  logic [CRC_W-1:0] crc_reg, crc_next;
  logic [CRC_W-1:0] crc_value_reg, crc_value_next;
  logic             crc_ok_reg, crc_ok_next;
  logic             err_orphan_reg, err_orphan_next;
  logic             err_restart_reg, err_restart_next;

  logic                  accept;
  logic                  take_beat;
  logic [CRC_W-1:0]      step_base;
  logic [DATA_BYTES-1:0] step_keep;
  logic [CRC_W-1:0]      step_crc;

  // Consuming the held result frees the slot in the same cycle.
  assign in_ready  = (state_reg != DONE) | out_ready;
  assign accept    = in_valid & in_ready;
  assign step_base = in_sof ? INIT_W : crc_reg;
  assign step_keep = in_eof ? in_keep : {DATA_BYTES{1'b1}};

  crc_beat_step #(
    .CRC_W      (CRC_W),
    .DATA_BYTES (DATA_BYTES),
    .POLY       (POLY),
    .REFLECT    (REFLECT)
  ) u_beat_step (
    .crc_in  (step_base),
    .data    (in_data),
    .keep    (step_keep),
    .crc_out (step_crc)
  );

  always_comb begin
    state_next       = state_reg;
    crc_next         = crc_reg;
    crc_value_next   = crc_value_reg;
    crc_ok_next      = crc_ok_reg;
    err_orphan_next  = 1'b0;
    err_restart_next = 1'b0;
    take_beat        = 1'b0;

    case (state_reg)
      IDLE: begin
        take_beat       = accept & in_sof;
        err_orphan_next = accept & ~in_sof;
      end
      RUN: begin
        take_beat        = accept;
        err_restart_next = accept & in_sof;
      end
      DONE: begin
        if (out_ready) begin
          state_next      = IDLE;
          take_beat       = accept & in_sof;
          err_orphan_next = accept & ~in_sof;
        end
      end
      default: state_next = IDLE;
    endcase

    if (take_beat) begin
      crc_next = step_crc;
      if (in_eof) begin
        state_next     = DONE;
        crc_value_next = step_crc ^ XOR_W;
        crc_ok_next    = (step_crc == RESIDUE_W);
      end else begin
        state_next = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      crc_reg         <= INIT_W;
      crc_value_reg   <= '0;
      crc_ok_reg      <= 1'b0;
      err_orphan_reg  <= 1'b0;
      err_restart_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      crc_reg         <= crc_next;
      crc_value_reg   <= crc_value_next;
      crc_ok_reg      <= crc_ok_next;
      err_orphan_reg  <= err_orphan_next;
      err_restart_reg <= err_restart_next;
    end
  end

  assign out_valid   = (state_reg == DONE);
  assign crc_value   = crc_value_reg;
  assign crc_ok      = crc_ok_reg;
  assign err_orphan  = err_orphan_reg;
  assign err_restart = err_restart_reg;

endmodule

// File: tb/tb_crc_frame_engine.sv
// Bench for crc_frame_engine: directed vectors plus randomized framing, all
// checked every cycle against a frame-level byte-queue CRC model.
module tb_crc_frame_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_keep = '0;
  logic        in_ready, out_valid, crc_ok, err_orphan, err_restart;
  logic [31:0] crc_value;

  logic        b_in_valid = 1'b0, b_in_sof = 1'b0, b_in_eof = 1'b0, b_out_ready = 1'b1;
  logic [7:0]  b_in_data = '0;
  logic [0:0]  b_in_keep = '0;
  logic        b_in_ready, b_out_valid, b_crc_ok, b_err_orphan, b_err_restart;
  logic [15:0] b_crc_value;

  int checks = 0;
  int failures = 0;
  bit rand_ready = 0;

  always #5 clk = ~clk;

  crc_frame_engine dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .in_keep(in_keep), .out_valid(out_valid),
    .out_ready(out_ready), .crc_value(crc_value), .crc_ok(crc_ok),
    .err_orphan(err_orphan), .err_restart(err_restart)
  );

  crc_frame_engine #(
    .CRC_W(16), .DATA_BYTES(1), .POLY(32'h1021), .INIT(32'hFFFF),
    .XOR_OUT(32'h0), .REFLECT(1'b0), .RESIDUE(32'h0)
  ) dut16 (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_sof(b_in_sof), .in_eof(b_in_eof), .in_keep(b_in_keep), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .crc_value(b_crc_value), .crc_ok(b_crc_ok),
    .err_orphan(b_err_orphan), .err_restart(b_err_restart)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rev(input logic [31:0] v, input int w);
    logic [31:0] o;
    o = '0;
    for (int i = 0; i < w; i++) o[w-1-i] = v[i];
    return o;
  endfunction

  // Textbook MSB-first division; reflected CRCs are handled by mirroring
  // the init, every data byte and the final register.
  function automatic logic [31:0] model_reg(input logic [7:0] q[$], input int w,
                                            input logic [31:0] poly, input logic [31:0] init,
                                            input bit refl);
    logic [31:0] mask, r;
    logic [7:0]  b;
    bit          top;
    mask = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 32'h1);
    r = refl ? rev(init & mask, w) : (init & mask);
    foreach (q[k]) begin
      b = refl ? 8'(rev(32'(q[k]), 8)) : q[k];
      for (int i = 7; i >= 0; i--) begin
        top = r[w-1] ^ b[i];
        r = (r << 1) & mask;
        if (top) r = r ^ (poly & mask);
      end
    end
    return refl ? rev(r, w) : r;
  endfunction

  // Frame-level model: open/pending flags plus the bytes of the open frame.
  logic [7:0]  fq[$];
  bit          m_open = 0, m_pend = 0, m_orph = 0, m_rest = 0, m_ok = 0;
  logic [31:0] m_crc = '0;
  int          frames = 0;

  always @(negedge clk) begin
    bit exp_ready, acc, nxt_orph, nxt_rest;
    logic [31:0] r;
    if (rst) begin
      m_open = 0; m_pend = 0; m_orph = 0; m_rest = 0;
      fq.delete();
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
    end else begin
      exp_ready = !m_pend || out_ready;
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("out_valid", 32'(out_valid), 32'(m_pend));
      check("err_orphan", 32'(err_orphan), 32'(m_orph));
      check("err_restart", 32'(err_restart), 32'(m_rest));
      if (m_pend) begin
        check("crc_value", crc_value, m_crc);
        check("crc_ok", 32'(crc_ok), 32'(m_ok));
      end
      acc = in_valid && exp_ready;
      if (m_pend && out_ready) m_pend = 0;
      nxt_orph = 0;
      nxt_rest = 0;
      if (acc) begin
        if (in_sof) begin
          nxt_rest = m_open;
          fq.delete();
          m_open = 1;
        end else if (!m_open) begin
          nxt_orph = 1;
        end
        if (m_open) begin
          for (int k = 0; k < 4; k++)
            if (!in_eof || in_keep[k]) fq.push_back(in_data[8*k +: 8]);
          if (in_eof) begin
            r = model_reg(fq, 32, 32'h04C11DB7, 32'hFFFFFFFF, 1);
            m_crc = r ^ 32'hFFFFFFFF;
            m_ok = (r == 32'hDEBB20E3);
            m_pend = 1;
            m_open = 0;
            frames++;
            $display("frame %0d bytes=%0d crc=%08h ok=%0d", frames, fq.size(), m_crc, m_ok);
          end
        end
      end
      m_orph = nxt_orph;
      m_rest = nxt_rest;
    end
  end

  always @(posedge clk)
    if (!rst && in_valid && in_eof)
      assert (((in_keep + 4'd1) & in_keep) == 4'd0) else $error("non-contiguous in_keep");

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input bit sof, input bit eof, input logic [3:0] keep);
    bit done;
    int n;
    in_valid = 1; in_data = d; in_sof = sof; in_eof = eof; in_keep = keep;
    done = 0;
    n = 0;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      tick();
      n++;
      if (!done && n > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: beat not accepted within %0d cycles", n);
        done = 1;
      end
    end
    in_valid = 0; in_sof = 0; in_eof = 0;
  endtask

  task automatic pop();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic send16(input logic [7:0] d, input bit sof, input bit eof, input bit keep);
    b_in_valid = 1; b_in_data = d; b_in_sof = sof; b_in_eof = eof; b_in_keep = keep;
    tick();
    b_in_valid = 0; b_in_sof = 0; b_in_eof = 0;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [7:0]  q[$];
    logic [7:0]  msg16 [11];
    logic [31:0] exp_1234;
    int          nb;
    bit          sof;
    bit          eof;

    for (int i = 0; i < 9; i++) q.push_back(8'(8'h31 + i));
    check("model_crc32", model_reg(q, 32, 32'h04C11DB7, 32'hFFFFFFFF, 1) ^ 32'hFFFFFFFF, 32'hCBF43926);
    check("model_crc16", model_reg(q, 16, 32'h1021, 32'hFFFF, 0), 32'h29B1);
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(8'(8'h31 + i));
    exp_1234 = model_reg(q, 32, 32'h04C11DB7, 32'hFFFFFFFF, 1) ^ 32'hFFFFFFFF;

    @(negedge clk);
    check("reset_crc_value", crc_value, 0);
    check("reset_crc_ok", 32'(crc_ok), 0);
    check("reset_err", 32'({err_orphan, err_restart}), 0);
    @(posedge clk);
    #3 rst = 0;
    sync();

    // "123456789" with a one-byte final beat
    send(32'h34333231, 1, 0, 4'hF);
    send(32'h38373635, 0, 0, 4'hF);
    send(32'h00000039, 0, 1, 4'b0001);
    @(negedge clk);
    check("t1_valid", 32'(out_valid), 1);
    check("t1_crc", crc_value, 32'hCBF43926);
    check("t1_ok", 32'(crc_ok), 0);
    sync();
    pop();

    // same data followed by its FCS: residue match
    send(32'h34333231, 1, 0, 4'hF);
    send(32'h38373635, 0, 0, 4'hF);
    send(32'hF4392639, 0, 0, 4'hF);
    send(32'h000000CB, 0, 1, 4'b0001);
    @(negedge clk);
    check("t2_crc", crc_value, 32'h2144DF1C);
    check("t2_ok", 32'(crc_ok), 1);
    sync();
    pop();

    // back-to-back frames with the consumer stalled for 5 cycles
    send(32'h34333231, 1, 0, 4'hF);
    send(32'h38373635, 0, 0, 4'hF);
    send(32'h00000039, 0, 1, 4'b0001);
    in_valid = 1; in_data = 32'h34333231; in_sof = 1; in_eof = 1; in_keep = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_out_valid", 32'(out_valid), 1);
      sync();
    end
    out_ready = 1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 1);
    check("release_crc", crc_value, 32'hCBF43926);
    sync();
    in_valid = 0; in_sof = 0; in_eof = 0; out_ready = 0;
    @(negedge clk);
    check("second_valid", 32'(out_valid), 1);
    check("second_crc", crc_value, exp_1234);
    sync();
    pop();

    // orphan beat, then a restart mid-frame
    send(32'hAABBCCDD, 0, 0, 4'hF);
    @(negedge clk);
    check("orphan_pulse", 32'(err_orphan), 1);
    check("orphan_no_valid", 32'(out_valid), 0);
    sync();
    @(negedge clk);
    check("orphan_one_cycle", 32'(err_orphan), 0);
    sync();
    send(32'h64636261, 1, 0, 4'hF);
    send(32'h34333231, 1, 0, 4'hF);
    @(negedge clk);
    check("restart_pulse", 32'(err_restart), 1);
    sync();
    send(32'h38373635, 0, 0, 4'hF);
    send(32'h00000039, 0, 1, 4'b0001);
    @(negedge clk);
    check("restart_crc", crc_value, 32'hCBF43926);
    sync();
    pop();

    // asynchronous reset mid-frame
    send(32'h34333231, 1, 0, 4'hF);
    #2 rst = 1;
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_ready", 32'(in_ready), 1);
    @(posedge clk);
    #3 rst = 0;
    send(32'h34333231, 1, 0, 4'hF);
    send(32'h38373635, 0, 0, 4'hF);
    send(32'h00000039, 0, 1, 4'b0001);
    @(negedge clk);
    check("postrst_crc", crc_value, 32'hCBF43926);
    sync();
    pop();

    // empty frame: sof & eof with keep == 0
    send(32'h12345678, 1, 1, 4'h0);
    @(negedge clk);
    check("empty_valid", 32'(out_valid), 1);
    check("empty_crc", crc_value, 32'h0);
    sync();
    pop();

    // randomized framing, partial beats, orphans, restarts and backpressure
    rand_ready = 1;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) send($urandom, 0, 0, 4'hF);
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        sof = (b == 0) || ($urandom_range(0, 15) == 0);
        eof = (b == nb - 1);
        send($urandom, sof, eof, eof ? 4'((5'd1 << $urandom_range(0, 4)) - 5'd1) : 4'hF);
      end
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_ready = 0;
    out_ready = 1;
    repeat (4) tick();
    out_ready = 0;

    // CRC-16/CCITT-FALSE, MSB-first, one byte per beat
    for (int i = 0; i < 9; i++) msg16[i] = 8'(8'h31 + i);
    msg16[9] = 8'h29;
    msg16[10] = 8'hB1;
    for (int i = 0; i < 9; i++) send16(msg16[i], i == 0, i == 8, 1'b1);
    @(negedge clk);
    check("c16_valid", 32'(b_out_valid), 1);
    check("c16_crc", 32'(b_crc_value), 32'h29B1);
    check("c16_ok", 32'(b_crc_ok), 0);
    sync();
    for (int i = 0; i < 11; i++) send16(msg16[i], i == 0, i == 10, 1'b1);
    @(negedge clk);
    check("c16_fcs_crc", 32'(b_crc_value), 32'h0);
    check("c16_fcs_ok", 32'(b_crc_ok), 1);
    sync();
    send16(8'h55, 1, 1, 1'b0);
    @(negedge clk);
    check("c16_empty_valid", 32'(b_out_valid), 1);
    check("c16_empty_crc", 32'(b_crc_value), 32'hFFFF);
    sync();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
